alu_packet_engine: RTL and testbench
====================================

ALU_PACKET_ENGINE -- requirements
Module: alu_packet_engine

Interface
REQ-001 SHALL have no parameters; the data width is fixed at 8 bits.
REQ-002 Port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 Port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port s_axis_tdata, input, 8 bits: command byte from the UART receiver.
REQ-005 Port s_axis_tvalid, input, 1 bit: the input byte is valid.
REQ-006 Port s_axis_tready, output, 1 bit: the engine accepts the input byte.
REQ-007 Port m_axis_tdata, output, 8 bits: response byte to the UART transmitter.
REQ-008 Port m_axis_tvalid, output, 1 bit: the output byte is valid.
REQ-009 Port m_axis_tready, input, 1 bit: the transmitter accepts the output byte.
REQ-010 Port busy_o, output, 1 bit: high whenever the state is not OPCODE.
REQ-011 Port err_o, output, 1 bit: one-cycle pulse when an unknown opcode is received.

Function
REQ-012 An input byte SHALL transfer on a cycle where s_axis_tvalid and s_axis_tready are both high; an output byte SHALL transfer on a cycle where m_axis_tvalid and m_axis_tready are both high.
REQ-013 m_axis_tdata and m_axis_tvalid SHALL be registered; once m_axis_tvalid is high, m_axis_tdata SHALL stay stable until the transfer completes.
REQ-014 Packet format SHALL be: opcode, reserved byte, length low byte, length high byte, then payload; length is the total packet bytes including the 4-byte header.
REQ-015 State machine states: OPCODE, RSVD, LEN_LO, LEN_HI, ECHO, ADD, SEND_RES, DISCARD.
REQ-016 In OPCODE, RSVD, LEN_LO, LEN_HI, ADD and DISCARD, s_axis_tready SHALL be 1; each accepted byte advances the state OPCODE->RSVD->LEN_LO->LEN_HI.
REQ-017 Payload count SHALL be the 16-bit value (length - 4) computed at LEN_HI acceptance, saturating at 0 when length < 4.
REQ-018 Opcode 0xEC (echo): when the payload count is greater than 0, LEN_HI SHALL go to ECHO; otherwise LEN_HI SHALL go to OPCODE.
REQ-019 In ECHO: s_axis_tready = !m_axis_tvalid | m_axis_tready; each accepted byte is loaded into the output register unchanged; the state returns to OPCODE after the last payload byte is accepted.
REQ-020 Opcode 0xAD (add32): the accumulator SHALL clear at LEN_HI acceptance; LEN_HI SHALL go to ADD when the payload count is greater than 0, otherwise to SEND_RES.
REQ-021 In ADD: payload bytes SHALL form little-endian 32-bit operands, each added to the accumulator modulo 2^32.
REQ-022 A trailing partial operand (payload count not a multiple of 4) SHALL be zero-extended in its upper bytes and added.
REQ-023 After the last payload byte, the state SHALL go to SEND_RES.
REQ-024 SEND_RES SHALL emit the 4 accumulator bytes least significant first, hold s_axis_tready at 0, and return to OPCODE after the 4th transfer.
REQ-025 Any other opcode: err_o SHALL pulse for one cycle at opcode acceptance; the header SHALL still be parsed; LEN_HI SHALL go to DISCARD, or to OPCODE if the payload count is 0.
REQ-026 DISCARD SHALL consume the payload count bytes with no output, then go to OPCODE.
REQ-027 In SEND_RES and on the final ECHO byte, the next packet's opcode SHALL NOT be accepted until the state is OPCODE and the output register is free.
REQ-028 In OPCODE, s_axis_tready = !m_axis_tvalid.
REQ-029 The payload down-counter SHALL be 16 bits and SHALL NOT wrap below 0.
REQ-030 Length 0xFFFF SHALL yield 65531 payload bytes.

Reset
REQ-031 While reset_i is high, the engine SHALL be in state OPCODE with m_axis_tvalid=0, m_axis_tdata=0x00, s_axis_tready=0, busy_o=0, err_o=0, accumulator=0 and counters=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; any pending output byte SHALL be dropped and not retransmitted.
REQ-033 On the first clock edge after reset_i deasserts, the engine SHALL be ready for an opcode.

Verification
REQ-034 Echo: EC 00 07 00 41 42 43 with m_axis_tready=1 -> outputs 41 42 43, then busy_o=0.
REQ-035 Add32: AD 00 0C 00 01 00 00 00 FF FF FF FF -> outputs 00 00 00 00 (wrap-around).
REQ-036 Add32 partial operand: AD 00 06 00 10 20 -> outputs 10 20 00 00; header-only AD 00 04 00 -> outputs 00 00 00 00.
REQ-037 Unknown opcode: 55 00 06 00 AA BB, then EC 00 05 00 5A -> err_o pulses once, the AA BB bytes produce no output, then 5A is output.
REQ-038 Backpressure: echo with m_axis_tready toggling randomly -> no byte lost or duplicated, and m_axis_tdata stays stable while stalled.
REQ-039 Reset pulse after AD 00 08 00 01 -> no output; a subsequent AD 00 08 00 02 00 00 00 -> outputs 02 00 00 00.

Source files
------------

// File: rtl/alu_packet_engine.sv
// alu_packet_engine: byte-stream command engine (echo / add32 / discard).
// Ports: clk_i, reset_i (async, active high); s_axis_* command byte
// input; m_axis_* registered response byte output; busy_o = not idle;
// err_o = one-cycle pulse after an unknown opcode is accepted.
module alu_packet_engine (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [2:0] OPCODE   = 3'd0;
  localparam logic [2:0] RSVD     = 3'd1;
  localparam logic [2:0] LEN_LO   = 3'd2;
  localparam logic [2:0] LEN_HI   = 3'd3;
  localparam logic [2:0] ECHO     = 3'd4;
  localparam logic [2:0] ADD      = 3'd5;
  localparam logic [2:0] SEND_RES = 3'd6;
  localparam logic [2:0] DISCARD  = 3'd7;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;

  logic [2:0]  state;
  logic [7:0]  op;
  logic [7:0]  len_lo;
  logic [15:0] cnt;
  logic [31:0] acc;
  logic [1:0]  pos;
  logic [2:0]  sent;

  logic        s_fire;
  logic        m_fire;
  logic        out_free;
  logic [15:0] len_full;
  logic [15:0] pay;
  logic [15:0] cnt_dec;
  logic        last;
  logic [31:0] acc_add;
  logic [7:0]  res_byte;
  logic        op_known;

  assign s_fire   = s_axis_tvalid & s_axis_tready;
  assign m_fire   = m_axis_tvalid & m_axis_tready;
  assign out_free = ~m_axis_tvalid | m_axis_tready;
  assign busy_o   = (state != OPCODE);

  assign len_full = {s_axis_tdata, len_lo};
  assign pay      = (len_full < 16'd4) ? 16'd0
                                       : len_full - 16'd4;
  assign cnt_dec  = (cnt == 16'd0) ? 16'd0 : cnt - 16'd1;
  assign last     = (cnt <= 16'd1);

  // Adding each byte at its lane position is the same modulo 2^32 as
  // assembling the little-endian word first; a partial word is then
  // implicitly zero-extended.
  assign acc_add  = acc + (32'(s_axis_tdata) << {pos, 3'b000});
  assign res_byte = 8'(acc >> {sent[1:0], 3'b000});
  assign op_known = (s_axis_tdata == OP_ECHO) ||
                    (s_axis_tdata == OP_ADD);

  always_comb begin
    s_axis_tready = 1'b0;
    if (!reset_i) begin
      unique case (state)
        OPCODE:   s_axis_tready = ~m_axis_tvalid;
        RSVD:     s_axis_tready = 1'b1;
        LEN_LO:   s_axis_tready = 1'b1;
        LEN_HI:   s_axis_tready = 1'b1;
        ECHO:     s_axis_tready = out_free;
        ADD:      s_axis_tready = 1'b1;
        SEND_RES: s_axis_tready = 1'b0;
        DISCARD:  s_axis_tready = 1'b1;
        default:  s_axis_tready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= OPCODE;
      op            <= 8'h00;
      len_lo        <= 8'h00;
      cnt           <= 16'd0;
      acc           <= 32'd0;
      pos           <= 2'd0;
      sent          <= 3'd0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (m_fire) m_axis_tvalid <= 1'b0;
      unique case (state)
        OPCODE: begin
          if (s_fire) begin
            op    <= s_axis_tdata;
            err_o <= ~op_known;
            state <= RSVD;
          end
        end
        RSVD: begin
          if (s_fire) state <= LEN_LO;
        end
        LEN_LO: begin
          if (s_fire) begin
            len_lo <= s_axis_tdata;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (s_fire) begin
            cnt  <= pay;
            pos  <= 2'd0;
            sent <= 3'd0;
            if (op == OP_ECHO) begin
              state <= (pay != 16'd0) ? ECHO : OPCODE;
            end else if (op == OP_ADD) begin
              acc   <= 32'd0;
              state <= (pay != 16'd0) ? ADD : SEND_RES;
            end else begin
              state <= (pay != 16'd0) ? DISCARD : OPCODE;
            end
          end
        end
        ECHO: begin
          if (s_fire) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            cnt           <= cnt_dec;
            if (last) state <= OPCODE;
          end
        end
        ADD: begin
          if (s_fire) begin
            acc <= acc_add;
            pos <= pos + 2'd1;
            cnt <= cnt_dec;
            if (last) state <= SEND_RES;
          end
        end
        SEND_RES: begin
          if (sent == 3'd4) begin
            if (m_fire) state <= OPCODE;
          end else if (out_free) begin
            m_axis_tdata  <= res_byte;
            m_axis_tvalid <= 1'b1;
            sent          <= sent + 3'd1;
          end
        end
        DISCARD: begin
          if (s_fire) begin
            cnt <= cnt_dec;
            if (last) state <= OPCODE;
          end
        end
        default: state <= OPCODE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_packet_engine.sv
// tb_alu_packet_engine: directed + random packets against a
// packet-level reference model; checks outputs, err pulses, stalls.
module tb_alu_packet_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic       busy;
  logic       err;

  alu_packet_engine dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];

  int   checks = 0;
  int   errors = 0;
  bq_t  inq;
  bq_t  expq;
  int   exp_err = 0;
  int   got_err = 0;
  int   rdy_mode = 0;
  int   gap_mode = 0;
  logic acc_pend = 1'b0;
  logic stall = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  // One cycle: drive at negedge, sample what the next posedge takes.
  task automatic step();
    @(negedge clk);
    if (acc_pend) begin
      void'(inq.pop_front());
      s_tvalid = 1'b0;
      acc_pend = 1'b0;
    end
    if (!s_tvalid) begin
      s_tvalid = (inq.size() > 0) &&
                 (gap_mode == 0 || $urandom_range(3) != 0);
      s_tdata  = s_tvalid ? inq[0] : 8'h00;
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(1));
      default: m_tready = 1'b0;
    endcase
    #1;
    if (err) got_err++;
    if (stall) begin
      chk("hold_valid", 32'(m_tvalid), 32'd1);
      chk("hold_data", 32'(m_tdata), 32'(stall_data));
    end
    if (m_tvalid && m_tready) begin
      checks++;
      assert (expq.size() > 0) else begin
        errors++;
        $error("FAIL extra_out observed %0h expected none",
               m_tdata);
      end
      if (expq.size() > 0)
        chk("out_byte", 32'(m_tdata), 32'(expq.pop_front()));
    end
    stall      = m_tvalid && !m_tready;
    stall_data = m_tdata;
    if (s_tvalid && s_tready) acc_pend = 1'b1;
  endtask

  // Reference model: works on whole packets and 32-bit words.
  task automatic model_pkt(input bq_t p);
    logic [7:0]  op;
    int          len;
    int          pc;
    logic [31:0] sum;
    logic [31:0] w;
    op  = p[0];
    len = int'({p[3], p[2]});
    pc  = (len < 4) ? 0 : len - 4;
    foreach (p[i]) inq.push_back(p[i]);
    if (op == 8'hEC) begin
      for (int i = 0; i < pc; i++) expq.push_back(p[4 + i]);
    end else if (op == 8'hAD) begin
      sum = 32'd0;
      for (int i = 0; i < pc; i += 4) begin
        w = 32'd0;
        for (int j = 0; j < 4; j++)
          if (i + j < pc) w[8*j +: 8] = p[4 + i + j];
        sum = sum + w;
      end
      for (int j = 0; j < 4; j++) expq.push_back(sum[8*j +: 8]);
    end else begin
      exp_err++;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((inq.size() > 0 || expq.size() > 0 || busy ||
            m_tvalid) && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s_timeout observed %0d expected <%0d",
             tag, n, budget);
    end
    repeat (3) step();
    chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
    chk({tag, "_left"}, 32'(expq.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    inq      = {};
    s_tvalid = 1'b0;
    acc_pend = 1'b0;
    stall    = 1'b0;
    #2;
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_mdata", 32'(m_tdata), 32'd0);
    chk("rst_sready", 32'(s_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) step();
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("ready_after_rst", 32'(s_tready), 32'd1);
  endtask

  initial begin
    bq_t p;
    int  plen;
    int  sel;
    logic [7:0] op;
    logic [15:0] len;

    do_reset();

    model_pkt('{8'hEC, 8'h00, 8'h07, 8'h00,
                8'h41, 8'h42, 8'h43});
    drain("echo", 200);

    model_pkt('{8'hAD, 8'h00, 8'h0C, 8'h00,
                8'h01, 8'h00, 8'h00, 8'h00,
                8'hFF, 8'hFF, 8'hFF, 8'hFF});
    drain("add_wrap", 200);

    model_pkt('{8'hAD, 8'h00, 8'h06, 8'h00, 8'h10, 8'h20});
    model_pkt('{8'hAD, 8'h00, 8'h04, 8'h00});
    drain("add_part", 200);

    model_pkt('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB});
    model_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A});
    drain("unknown", 200);

    model_pkt('{8'hEC, 8'h00, 8'h02, 8'h00});
    model_pkt('{8'hAD, 8'h00, 8'h01, 8'h00});
    model_pkt('{8'h13, 8'h00, 8'h00, 8'h00});
    drain("short_len", 200);

    p = '{8'hEC, 8'h00, 8'h04, 8'h01};
    for (int i = 0; i < 256; i++) p.push_back(8'($urandom));
    model_pkt(p);
    drain("echo_256", 2000);

    rdy_mode = 1;
    p = '{8'hEC, 8'h00, 8'd24, 8'h00};
    for (int i = 0; i < 20; i++) p.push_back(8'($urandom));
    model_pkt(p);
    drain("echo_bp", 1000);

    rdy_mode = 0;
    inq = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h01};
    repeat (8) step();
    do_reset();
    model_pkt('{8'hAD, 8'h00, 8'h08, 8'h00,
                8'h02, 8'h00, 8'h00, 8'h00});
    drain("rst_add", 200);

    rdy_mode = 2;
    inq = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
    repeat (8) step();
    chk("pend_valid", 32'(m_tvalid), 32'd1);
    chk("pend_data", 32'(m_tdata), 32'h77);
    do_reset();
    rdy_mode = 0;
    model_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A});
    drain("rst_drop", 200);

    rdy_mode = 1;
    gap_mode = 1;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(2);
      if (sel == 0) op = 8'hEC;
      else if (sel == 1) op = 8'hAD;
      else begin
        op = 8'($urandom);
        while (op == 8'hEC || op == 8'hAD) op = 8'($urandom);
      end
      plen = $urandom_range(9);
      len  = 16'(plen + 4);
      if (plen == 0 && $urandom_range(1) == 1)
        len = 16'($urandom_range(3));
      p = {};
      p.push_back(op);
      p.push_back(8'($urandom));
      p.push_back(len[7:0]);
      p.push_back(len[15:8]);
      for (int i = 0; i < plen; i++) p.push_back(8'($urandom));
      model_pkt(p);
    end
    drain("random", 5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
